fp_addsub_arbiter: RTL and testbench



---
 rtl/fp_addsub_arbiter.sv | 209 ++++++++++++++++++++
 tb/tb_fp_addsub_arbiter.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_addsub_arbiter.sv
// Round-robin arbiter sharing one combinational FP32 add/sub unit between two
// requesters, with operands held stable for a multicycle adder path.

module Addition_Subtraction (
    input  logic [31:0] a_operand,
    input  logic [31:0] b_operand,
    input  logic        AddBar_Sub,
    output logic        Exception,
    output logic [31:0] result
);
    logic [31:0] b_eff, op_x, op_y;
    logic        swap, sx, sy, eff_sub, in_exc, ovf, rup;
    logic [7:0]  ex, ey, ex_e, ey_e, diff;
    logic [23:0] mx, my;
    logic [26:0] xs, ys, ys_full, norm;
    logic [27:0] sum;
    logic [4:0]  lz;
    logic [9:0]  sh, e_n, e_fin;
    logic [24:0] rnd;

    // Order operands by magnitude so the aligned difference never goes negative.
    assign b_eff   = {b_operand[31] ^ AddBar_Sub, b_operand[30:0]};
    assign swap    = b_operand[30:0] > a_operand[30:0];
    assign op_x    = swap ? b_eff : a_operand;
    assign op_y    = swap ? a_operand : b_eff;
    assign sx      = op_x[31];
    assign sy      = op_y[31];
    assign ex      = op_x[30:23];
    assign ey      = op_y[30:23];
    assign ex_e    = (ex == 8'd0) ? 8'd1 : ex;
    assign ey_e    = (ey == 8'd0) ? 8'd1 : ey;
    assign mx      = {ex != 8'd0, op_x[22:0]};
    assign my      = {ey != 8'd0, op_y[22:0]};
    assign diff    = ex_e - ey_e;
    assign eff_sub = sx ^ sy;
    assign in_exc  = (ex == 8'hFF) || (ey == 8'hFF);
    assign xs      = {mx, 3'b000};
    assign ys_full = {my, 3'b000};

    always_comb begin
        if (diff > 8'd26) begin
            ys = {26'd0, |my};
        end else begin
            ys = (ys_full >> diff)
               | {26'd0, |(ys_full & ~({27{1'b1}} << diff))};
        end
    end

    assign sum = eff_sub ? ({1'b0, xs} - {1'b0, ys})
                         : ({1'b0, xs} + {1'b0, ys});

    always_comb begin
        lz = 5'd27;
        for (int i = 0; i < 27; i++) begin
            if (sum[i]) lz = 5'(26 - i);
        end
    end

    // Left shift is capped so the exponent stops at 1 (gradual underflow).
    always_comb begin
        sh   = 10'd0;
        norm = 27'd0;
        e_n  = 10'd0;
        if (sum[27]) begin
            norm = {sum[27:2], sum[1] | sum[0]};
            e_n  = {2'b00, ex_e} + 10'd1;
        end else begin
            sh   = (10'(lz) > 10'(ex_e) - 10'd1) ? 10'(ex_e) - 10'd1
                                                  : 10'(lz);
            norm = sum[26:0] << sh;
            e_n  = 10'(ex_e) - sh;
        end
    end

    assign rup   = norm[2] & (norm[1] | norm[0] | norm[3]);
    assign rnd   = {1'b0, norm[26:3]} + 25'(rup);
    assign e_fin = rnd[24] ? e_n + 10'd1 : (rnd[23] ? e_n : 10'd0);
    assign ovf   = e_fin >= 10'd255;

    assign Exception = in_exc || ovf;

    always_comb begin
        if (in_exc) begin
            result = 32'h7FC0_0000;
        end else if (ovf) begin
            result = {sx, 8'hFF, 23'd0};
        end else if (sum == 28'd0) begin
            result = {eff_sub ? 1'b0 : sx, 31'd0};
        end else begin
            result = {sx, e_fin[7:0], rnd[24] ? 23'd0 : rnd[22:0]};
        end
    end
endmodule

module fp_addsub_arbiter #(
    parameter int CALC_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic        req0_sub,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    input  logic        req1_sub,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [31:0] rsp_result,
    output logic        rsp_exception,
    output logic        busy,
    output logic [15:0] cnt0,
    output logic [15:0] cnt1
);
    if (CALC_CYCLES < 1 || CALC_CYCLES > 15) begin : g_bad_cfg
        $fatal(1, "fp_addsub_arbiter: CALC_CYCLES must be 1..15");
    end

    typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;

    state_t      state_q;
    logic        last_grant_q, id_q, sub_q;
    logic [31:0] a_q, b_q;
    logic [3:0]  calc_cnt_q;
    logic        rsp_valid_q, rsp_id_q, rsp_exc_q;
    logic [31:0] rsp_result_q;
    logic [15:0] cnt0_q, cnt1_q;
    logic        grant, accept, add_exc;
    logic [31:0] add_res;

    // On a tie the requester that did not win last time gets the slot.
    assign grant  = req1_valid && (!req0_valid || !last_grant_q);
    assign req0_ready = (state_q == IDLE) && !grant;
    assign req1_ready = (state_q == IDLE) && grant;
    assign accept = grant ? (req1_valid && req1_ready)
                          : (req0_valid && req0_ready);

    Addition_Subtraction u_add (
        .a_operand (a_q),
        .b_operand (b_q),
        .AddBar_Sub(sub_q),
        .Exception (add_exc),
        .result    (add_res)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            id_q         <= 1'b0;
            sub_q        <= 1'b0;
            a_q          <= 32'd0;
            b_q          <= 32'd0;
            calc_cnt_q   <= 4'd0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_exc_q    <= 1'b0;
            rsp_result_q <= 32'd0;
            cnt0_q       <= 16'd0;
            cnt1_q       <= 16'd0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        a_q          <= grant ? req1_a : req0_a;
                        b_q          <= grant ? req1_b : req0_b;
                        sub_q        <= grant ? req1_sub : req0_sub;
                        id_q         <= grant;
                        last_grant_q <= grant;
                        calc_cnt_q   <= 4'(CALC_CYCLES - 1);
                        state_q      <= CALC;
                    end
                end
                CALC: begin
                    if (calc_cnt_q != 4'd0) begin
                        calc_cnt_q <= calc_cnt_q - 4'd1;
                    end else begin
                        rsp_result_q <= add_res;
                        rsp_exc_q    <= add_exc;
                        rsp_id_q     <= id_q;
                        rsp_valid_q  <= 1'b1;
                        state_q      <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= IDLE;
                        if (rsp_id_q) cnt1_q <= cnt1_q + 16'd1;
                        else          cnt0_q <= cnt0_q + 16'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rsp_valid     = rsp_valid_q;
    assign rsp_id        = rsp_id_q;
    assign rsp_result    = rsp_result_q;
    assign rsp_exception = rsp_exc_q;
    assign busy          = (state_q != IDLE);
    assign cnt0          = cnt0_q;
    assign cnt1          = cnt1_q;
endmodule

// File: tb/tb_fp_addsub_arbiter.sv
// Directed bench for fp_addsub_arbiter: one instance with CALC_CYCLES=1 and
// one with CALC_CYCLES=3 share the same stimulus.

module tb_fp_addsub_arbiter;
    logic        clk = 1'b0;
    logic        reset;
    logic        v0, v1, s0, s1, rr;
    logic [31:0] a0, b0, a1, b1;
    logic        rdy0 [2];
    logic        rdy1 [2];
    logic        rv   [2];
    logic        rid  [2];
    logic        rexc [2];
    logic        bsy  [2];
    logic [31:0] res  [2];
    logic [15:0] c0   [2];
    logic [15:0] c1   [2];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fp_addsub_arbiter #(.CALC_CYCLES(1)) u1 (
        .clk(clk), .reset(reset),
        .req0_valid(v0), .req0_ready(rdy0[0]), .req0_a(a0), .req0_b(b0),
        .req0_sub(s0),
        .req1_valid(v1), .req1_ready(rdy1[0]), .req1_a(a1), .req1_b(b1),
        .req1_sub(s1),
        .rsp_valid(rv[0]), .rsp_ready(rr), .rsp_id(rid[0]),
        .rsp_result(res[0]), .rsp_exception(rexc[0]), .busy(bsy[0]),
        .cnt0(c0[0]), .cnt1(c1[0])
    );

    fp_addsub_arbiter #(.CALC_CYCLES(3)) u3 (
        .clk(clk), .reset(reset),
        .req0_valid(v0), .req0_ready(rdy0[1]), .req0_a(a0), .req0_b(b0),
        .req0_sub(s0),
        .req1_valid(v1), .req1_ready(rdy1[1]), .req1_a(a1), .req1_b(b1),
        .req1_sub(s1),
        .rsp_valid(rv[1]), .rsp_ready(rr), .rsp_id(rid[1]),
        .rsp_result(res[1]), .rsp_exception(rexc[1]), .busy(bsy[1]),
        .cnt0(c0[1]), .cnt1(c1[1])
    );

    typedef struct {
        logic        id;
        logic [31:0] a;
        logic [31:0] b;
        logic        sub;
        logic [31:0] res;
        logic        exc;
        logic        chk_res;
    } vec_t;

    vec_t vecs [13];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        v0 = 1'b0;
        v1 = 1'b0;
        rr = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Issue one op on requester id, scramble the ports after accept and
    // wait for rsp_valid on instance k; lat = edges from accept to response.
    task automatic issue(input int k, input logic id, input logic [31:0] a,
                         input logic [31:0] b, input logic sub,
                         output int lat);
        @(negedge clk);
        if (id) begin
            v1 = 1'b1; a1 = a; b1 = b; s1 = sub;
        end else begin
            v0 = 1'b1; a0 = a; b0 = b; s0 = sub;
        end
        #1;
        chk($sformatf("ready%0d_at_accept", id),
            32'(id ? rdy1[k] : rdy0[k]), 32'd1);
        @(posedge clk);
        #1;
        v0 = 1'b0; v1 = 1'b0;
        a0 = 32'hDEAD_BEEF; b0 = 32'h1234_5678; s0 = ~sub;
        a1 = 32'hCAFE_F00D; b1 = 32'h7F7F_7F7F; s1 = ~sub;
        lat = 0;
        while (!rv[k] && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    initial begin
        int lat;
        int e0, e1;
        int acc [$];
        int rids [$];
        logic [31:0] rres [$];

        vecs[0]  = '{1'b0, 32'h3F80_0000, 32'h4000_0000, 1'b0, 32'h4040_0000, 1'b0, 1'b1};
        vecs[1]  = '{1'b1, 32'h4040_0000, 32'h3F80_0000, 1'b1, 32'h4000_0000, 1'b0, 1'b1};
        vecs[2]  = '{1'b0, 32'h3F80_0000, 32'h3F80_0000, 1'b1, 32'h0000_0000, 1'b0, 1'b1};
        vecs[3]  = '{1'b1, 32'hC000_0000, 32'h3F80_0000, 1'b0, 32'hBF80_0000, 1'b0, 1'b1};
        vecs[4]  = '{1'b0, 32'h3FC0_0000, 32'h3FC0_0000, 1'b0, 32'h4040_0000, 1'b0, 1'b1};
        vecs[5]  = '{1'b1, 32'h4120_0000, 32'h40A0_0000, 1'b1, 32'h40A0_0000, 1'b0, 1'b1};
        vecs[6]  = '{1'b0, 32'h3F00_0000, 32'h3E80_0000, 1'b0, 32'h3F40_0000, 1'b0, 1'b1};
        vecs[7]  = '{1'b1, 32'h0000_0000, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0, 1'b1};
        vecs[8]  = '{1'b0, 32'h42C8_0000, 32'hC2C8_0000, 1'b0, 32'h0000_0000, 1'b0, 1'b1};
        vecs[9]  = '{1'b1, 32'h3F80_0000, 32'hC000_0000, 1'b1, 32'h4040_0000, 1'b0, 1'b1};
        vecs[10] = '{1'b0, 32'h3F80_0000, 32'h3380_0000, 1'b0, 32'h3F80_0000, 1'b0, 1'b1};
        vecs[11] = '{1'b1, 32'h3F80_0001, 32'h3380_0000, 1'b0, 32'h3F80_0002, 1'b0, 1'b1};
        vecs[12] = '{1'b0, 32'h7F80_0000, 32'h3F80_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b0};

        reset = 1'b1;
        v0 = 1'b0; v1 = 1'b0; s0 = 1'b0; s1 = 1'b0; rr = 1'b1;
        a0 = 32'd0; b0 = 32'd0; a1 = 32'd0; b1 = 32'd0;
        do_reset();
        #1;
        chk("rst_rsp_valid", 32'(rv[0]), 32'd0);
        chk("rst_rsp_id", 32'(rid[0]), 32'd0);
        chk("rst_rsp_result", res[0], 32'd0);
        chk("rst_rsp_exc", 32'(rexc[0]), 32'd0);
        chk("rst_busy", 32'(bsy[0]), 32'd0);
        chk("rst_cnt0", 32'(c0[0]), 32'd0);
        chk("rst_cnt1", 32'(c1[0]), 32'd0);

        e0 = 0;
        e1 = 0;
        for (int i = 0; i < 13; i++) begin
            issue(0, vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].sub, lat);
            chk($sformatf("v%0d_latency", i), 32'(lat), 32'd1);
            chk($sformatf("v%0d_rsp_id", i), 32'(rid[0]), 32'(vecs[i].id));
            if (vecs[i].chk_res)
                chk($sformatf("v%0d_result", i), res[0], vecs[i].res);
            chk($sformatf("v%0d_exc", i), 32'(rexc[0]), 32'(vecs[i].exc));
            if (vecs[i].id) e1++; else e0++;
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_valid_drop", i), 32'(rv[0]), 32'd0);
            chk($sformatf("v%0d_cnt0", i), 32'(c0[0]), 32'(e0));
            chk($sformatf("v%0d_cnt1", i), 32'(c1[0]), 32'(e1));
        end

        do_reset();
        issue(1, 1'b1, 32'h4040_0000, 32'h3F80_0000, 1'b1, lat);
        chk("cc3_latency", 32'(lat), 32'd3);
        chk("cc3_rsp_id", 32'(rid[1]), 32'd1);
        chk("cc3_result", res[1], 32'h4000_0000);
        chk("cc3_exc", 32'(rexc[1]), 32'd0);
        @(posedge clk);
        #1;
        chk("cc3_cnt1", 32'(c1[1]), 32'd1);
        chk("cc3_cnt0", 32'(c0[1]), 32'd0);

        do_reset();
        @(negedge clk);
        v0 = 1'b1; a0 = 32'h3F80_0000; b0 = 32'h3F80_0000; s0 = 1'b0;
        v1 = 1'b1; a1 = 32'h4000_0000; b1 = 32'h4000_0000; s1 = 1'b0;
        for (int cyc = 0; cyc < 60 && rids.size() < 4; cyc++) begin
            if (cyc != 0) @(negedge clk);
            #1;
            if (rdy0[0]) acc.push_back(0);
            else if (rdy1[0]) acc.push_back(1);
            if (rv[0]) begin
                rids.push_back(int'(rid[0]));
                rres.push_back(res[0]);
            end
        end
        v0 = 1'b0;
        v1 = 1'b0;
        chk("rr_accept_count", 32'(acc.size() >= 4), 32'd1);
        chk("rr_resp_count", 32'(rids.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < acc.size())
                chk($sformatf("rr_accept%0d", i), 32'(acc[i]), 32'(i % 2));
            if (i < rids.size()) begin
                chk($sformatf("rr_rsp_id%0d", i), 32'(rids[i]), 32'(i % 2));
                chk($sformatf("rr_result%0d", i), rres[i],
                    (i % 2) ? 32'h4080_0000 : 32'h4000_0000);
            end
        end
        @(posedge clk);
        #1;
        chk("rr_cnt0", 32'(c0[0]), 32'd2);
        chk("rr_cnt1", 32'(c1[0]), 32'd2);

        do_reset();
        rr = 1'b0;
        issue(0, 1'b0, 32'h3F80_0000, 32'h4000_0000, 1'b0, lat);
        chk("bp_latency", 32'(lat), 32'd1);
        v0 = 1'b1;
        v1 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            chk($sformatf("bp_valid%0d", i), 32'(rv[0]), 32'd1);
            chk($sformatf("bp_result%0d", i), res[0], 32'h4040_0000);
            chk($sformatf("bp_ready0_%0d", i), 32'(rdy0[0]), 32'd0);
            chk($sformatf("bp_ready1_%0d", i), 32'(rdy1[0]), 32'd0);
            chk($sformatf("bp_busy%0d", i), 32'(bsy[0]), 32'd1);
            chk($sformatf("bp_cnt0_%0d", i), 32'(c0[0]), 32'd0);
        end
        @(negedge clk);
        rr = 1'b1;
        v0 = 1'b0;
        v1 = 1'b0;
        @(posedge clk);
        #1;
        chk("bp_release_valid", 32'(rv[0]), 32'd0);
        chk("bp_release_busy", 32'(bsy[0]), 32'd0);
        chk("bp_release_cnt0", 32'(c0[0]), 32'd1);
        @(posedge clk);
        #1;
        chk("bp_cnt0_once", 32'(c0[0]), 32'd1);

        do_reset();
        @(negedge clk);
        v0 = 1'b1; a0 = 32'h3F80_0000; b0 = 32'h4000_0000; s0 = 1'b0;
        @(posedge clk);
        #1;
        chk("mid_busy_after_accept", 32'(bsy[0]), 32'd1);
        @(negedge clk);
        v0 = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_rst_valid", 32'(rv[0]), 32'd0);
        chk("mid_rst_busy", 32'(bsy[0]), 32'd0);
        chk("mid_rst_result", res[0], 32'd0);
        chk("mid_rst_busy_cc3", 32'(bsy[1]), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk($sformatf("mid_no_pulse%0d", i), 32'(rv[0]), 32'd0);
        end
        chk("mid_cnt0", 32'(c0[0]), 32'd0);
        chk("mid_cnt1", 32'(c1[0]), 32'd0);
        @(negedge clk);
        v0 = 1'b1; a0 = 32'h3F00_0000; b0 = 32'h3E80_0000; s0 = 1'b0;
        v1 = 1'b1; a1 = 32'h4000_0000; b1 = 32'h4000_0000; s1 = 1'b0;
        #1;
        chk("mid_tie_ready0", 32'(rdy0[0]), 32'd1);
        chk("mid_tie_ready1", 32'(rdy1[0]), 32'd0);
        @(posedge clk);
        #1;
        v0 = 1'b0;
        v1 = 1'b0;
        lat = 0;
        while (!rv[0] && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("mid_tie_rsp_id", 32'(rid[0]), 32'd0);
        chk("mid_tie_result", res[0], 32'h3F40_0000);

        do_reset();
        @(negedge clk);
        force u1.cnt0_q = 16'hFFFF;
        @(negedge clk);
        release u1.cnt0_q;
        #1;
        chk("wrap_preload", 32'(c0[0]), 32'h0000_FFFF);
        issue(0, 1'b0, 32'h3F80_0000, 32'h3F80_0000, 1'b0, lat);
        chk("wrap_result", res[0], 32'h4000_0000);
        @(posedge clk);
        #1;
        chk("wrap_cnt0", 32'(c0[0]), 32'd0);
        chk("wrap_cnt1", 32'(c1[0]), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
